// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - radix-2 DIT stage/address sequencer for an in-place FFT
module fft_stage_sequencer #(
    parameter int LOG2_N       = 6,
    parameter int BFLY_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(LOG2_N)-1:0] stage,
    output logic                      rd_en,
    output logic [LOG2_N-1:0]         rd_addr_a,
    output logic [LOG2_N-1:0]         rd_addr_b,
    output logic [LOG2_N-2:0]         tw_addr,
    output logic                      bf_in_valid,
    output logic                      wr_en,
    output logic [LOG2_N-1:0]         wr_addr_a,
    output logic [LOG2_N-1:0]         wr_addr_b
);

    localparam int KW    = LOG2_N - 1;
    localparam int SW    = $clog2(LOG2_N);
    localparam int DEPTH = BFLY_LATENCY + 1;
    localparam int DW    = $clog2(BFLY_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [SW-1:0]   cur_stage;
    logic [DW-1:0]   dcnt;

    logic              dly_en [DEPTH];
    logic [LOG2_N-1:0] dly_a  [DEPTH];
    logic [LOG2_N-1:0] dly_b  [DEPTH];

    logic [SW-1:0]     gen_stage;
    logic [KW-1:0]     gen_k;
    logic [LOG2_N-1:0] kx, half, pos, gen_a, gen_b;
    logic [KW-1:0]     gen_tw;

    // Addresses for the butterfly that will be issued on the next edge.
    always_comb begin
        gen_stage = '0;
        gen_k     = '0;
        if (state == ISSUE) begin
            gen_stage = cur_stage;
            gen_k     = k + KW'(1);
        end else if (state == DRAIN) begin
            gen_stage = cur_stage + SW'(1);
        end
    end

    always_comb begin
        kx     = {1'b0, gen_k};
        half   = LOG2_N'(1) << gen_stage;
        pos    = kx & (half - LOG2_N'(1));
        gen_a  = ((kx & ~(half - LOG2_N'(1))) << 1) | pos;
        gen_b  = gen_a | half;
        gen_tw = KW'({pos, {KW{1'b0}}} >> gen_stage);
    end

    assign bf_in_valid = dly_en[0];
    assign wr_en       = dly_en[DEPTH-1];
    assign wr_addr_a   = dly_a[DEPTH-1];
    assign wr_addr_b   = dly_b[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            cur_stage <= '0;
            dcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            stage     <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dly_en[i] <= 1'b0;
                dly_a[i]  <= '0;
                dly_b[i]  <= '0;
            end
        end else begin
            dly_en[0] <= rd_en;
            dly_a[0]  <= rd_addr_a;
            dly_b[0]  <= rd_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                dly_en[i] <= dly_en[i-1];
                dly_a[i]  <= dly_a[i-1];
                dly_b[i]  <= dly_b[i-1];
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        cur_stage <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        stage     <= gen_stage;
                        rd_addr_a <= gen_a;
                        rd_addr_b <= gen_b;
                        tw_addr   <= gen_tw;
                    end
                end
                ISSUE: begin
                    if (&k) begin
                        state     <= DRAIN;
                        k         <= '0;
                        dcnt      <= '0;
                        rd_en     <= 1'b0;
                        stage     <= '0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        tw_addr   <= '0;
                    end else begin
                        k         <= gen_k;
                        stage     <= gen_stage;
                        rd_addr_a <= gen_a;
                        rd_addr_b <= gen_b;
                        tw_addr   <= gen_tw;
                    end
                end
                DRAIN: begin
                    // The last write-back of this stage is on the wires when dcnt hits the latency.
                    if (dcnt == DW'(BFLY_LATENCY)) begin
                        if (cur_stage == SW'(LOG2_N - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            cur_stage <= gen_stage;
                            k         <= '0;
                            rd_en     <= 1'b1;
                            stage     <= gen_stage;
                            rd_addr_a <= gen_a;
                            rd_addr_b <= gen_b;
                            tw_addr   <= gen_tw;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, start0, reset1, start1;
    logic busy0, done0, rd_en0, bfv0, wr_en0;
    logic [2:0] stage0;
    logic [5:0] ra0, rb0, wa0, wb0;
    logic [4:0] tw0;
    logic busy1, done1, rd_en1, bfv1, wr_en1;
    logic [0:0] stage1;
    logic [1:0] ra1, rb1, wa1, wb1;
    logic [0:0] tw1;

    fft_stage_sequencer dut0 (
        .clk(clk), .reset(reset0), .start(start0), .busy(busy0), .done(done0),
        .stage(stage0), .rd_en(rd_en0), .rd_addr_a(ra0), .rd_addr_b(rb0),
        .tw_addr(tw0), .bf_in_valid(bfv0), .wr_en(wr_en0),
        .wr_addr_a(wa0), .wr_addr_b(wb0)
    );

    fft_stage_sequencer #(.LOG2_N(2), .BFLY_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .busy(busy1), .done(done1),
        .stage(stage1), .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1),
        .tw_addr(tw1), .bf_in_valid(bfv1), .wr_en(wr_en1),
        .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    typedef struct {int v; int s; int a; int b; int tw;} rd_t;
    typedef struct {int busy; int done; int stage; int rd_en; int a; int b; int tw;
                    int bfv; int wr_en; int wa; int wb;} out_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit check_on = 0;
    int st[2];
    bit act[2];
    int c0 = 1 << 30;
    int c2 = 0;
    int e0 = 0;
    int busy_cnt = 0;
    int cov[8][64];
    int rd_log0[$], wr_log0[$], done_log0[$], rd_log1[$], done_log1[$], pa1[$], pb1[$];
    out_t a0, a1;
    rd_t r;
    out_t m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Read issued at transform-relative cycle t (t=1 is the first read).
    function automatic rd_t rd_model(int L, int BL, int t);
        rd_t o = '{0, 0, 0, 0, 0};
        int p = (1 << (L - 1)) + BL + 1;
        int s, kk, half, pos;
        if (t < 1 || t > L * p) return o;
        s  = (t - 1) / p;
        kk = (t - 1) % p;
        if (kk >= (1 << (L - 1))) return o;
        half = 2 ** s;
        pos  = kk % half;
        o.v  = 1;
        o.s  = s;
        o.a  = (kk / half) * 2 * half + pos;
        o.b  = o.a + half;
        o.tw = pos * (2 ** (L - 1 - s));
        return o;
    endfunction

    function automatic out_t model_out(int L, int BL, int t);
        out_t o;
        rd_t rr, wr;
        int total = L * ((1 << (L - 1)) + BL + 1);
        rr = rd_model(L, BL, t);
        wr = rd_model(L, BL, t - BL - 1);
        o.busy  = (t >= 1 && t <= total) ? 1 : 0;
        o.done  = (t == total + 1) ? 1 : 0;
        o.stage = rr.s;
        o.rd_en = rr.v;
        o.a     = rr.a;
        o.b     = rr.b;
        o.tw    = rr.tw;
        o.bfv   = rd_model(L, BL, t - 1).v;
        o.wr_en = wr.v;
        o.wa    = wr.a;
        o.wb    = wr.b;
        return o;
    endfunction

    task automatic compare(string u, out_t g, out_t e);
        check({u, ".busy"},  g.busy,  e.busy);
        check({u, ".done"},  g.done,  e.done);
        check({u, ".stage"}, g.stage, e.stage);
        check({u, ".rd_en"}, g.rd_en, e.rd_en);
        check({u, ".rd_a"},  g.a,     e.a);
        check({u, ".rd_b"},  g.b,     e.b);
        check({u, ".tw"},    g.tw,    e.tw);
        check({u, ".bfv"},   g.bfv,   e.bfv);
        check({u, ".wr_en"}, g.wr_en, e.wr_en);
        check({u, ".wr_a"},  g.wa,    e.wa);
        check({u, ".wr_b"},  g.wb,    e.wb);
    endtask

    task automatic upd(int u, int L, int BL, logic rst, logic stt);
        int t = cyc - st[u];
        bit idle = !act[u] || (t > L * ((1 << (L - 1)) + BL + 1) + 1);
        if (rst) act[u] = 0;
        else if (stt && idle) begin
            act[u] = 1;
            st[u]  = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            a0 = '{int'(busy0), int'(done0), int'(stage0), int'(rd_en0), int'(ra0), int'(rb0),
                   int'(tw0), int'(bfv0), int'(wr_en0), int'(wa0), int'(wb0)};
            a1 = '{int'(busy1), int'(done1), int'(stage1), int'(rd_en1), int'(ra1), int'(rb1),
                   int'(tw1), int'(bfv1), int'(wr_en1), int'(wa1), int'(wb1)};
            compare("u0", a0, model_out(6, 4, act[0] ? cyc - st[0] : -1000));
            compare("u1", a1, model_out(2, 1, act[1] ? cyc - st[1] : -1000));
            upd(0, 6, 4, reset0, start0);
            upd(1, 2, 1, reset1, start1);
            if (rd_en0) rd_log0.push_back(cyc);
            if (wr_en0) wr_log0.push_back(cyc);
            if (done0) done_log0.push_back(cyc);
            if (rd_en1) begin
                rd_log1.push_back(cyc);
                pa1.push_back(int'(ra1));
                pb1.push_back(int'(rb1));
            end
            if (done1) done_log1.push_back(cyc);
            if (cyc > c0 && cyc < c0 + 224) begin
                if (busy0) busy_cnt++;
                if (rd_en0) begin
                    cov[stage0][ra0]++;
                    cov[stage0][rb0]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int n);
        while (cyc < n) tick();
    endtask

    function automatic int qget(int q[$], int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    initial begin
        int bad;
        reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tick(); tick();
        check_on = 1;
        tick();
        reset0 = 1'b0; reset1 = 1'b0;
        tick();

        // Hand-computed anchors for the model itself.
        r = rd_model(6, 4, 1);    check("pin t1.a", r.a, 0);   check("pin t1.b", r.b, 1);   check("pin t1.tw", r.tw, 0);
        r = rd_model(6, 4, 39);   check("pin s1k1.a", r.a, 1); check("pin s1k1.b", r.b, 3); check("pin s1k1.tw", r.tw, 16);
        r = rd_model(6, 4, 217);  check("pin s5k31.a", r.a, 31); check("pin s5k31.b", r.b, 63); check("pin s5k31.tw", r.tw, 31);
        m = model_out(6, 4, 37);  check("pin wr37.en", m.wr_en, 1); check("pin wr37.a", m.wa, 62);
        m = model_out(6, 4, 38);  check("pin rd38.b", m.b, 2); check("pin rd38.stage", m.stage, 1);
        m = model_out(6, 4, 223); check("pin done223", m.done, 1); check("pin busy223", m.busy, 0);
        r = rd_model(2, 1, 5);    check("pin n4t5.b", r.b, 2);
        m = model_out(2, 1, 9);   check("pin n4done9", m.done, 1);

        start0 = 1'b1; c0 = cyc; tick(); start0 = 1'b0;
        repeat (4) tick();
        start1 = 1'b1; e0 = cyc; tick(); start1 = 1'b0;
        wait_until(c0 + 50);  start0 = 1'b1; tick(); start0 = 1'b0;
        wait_until(c0 + 223); start0 = 1'b1; tick(); start0 = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        wait_until(c0 + 224 + 100); reset0 = 1'b1; tick(); reset0 = 1'b0;
        repeat (5) tick();
        start0 = 1'b1; c2 = cyc; tick(); start0 = 1'b0;
        wait_until(c2 + 230);
        check_on = 0;

        check("first rd", qget(rd_log0, 0) - c0, 1);
        check("stage0 last wr", qget(wr_log0, 31) - c0, 37);
        check("stage1 first rd", qget(rd_log0, 32) - c0, 38);
        check("restart first rd", qget(rd_log0, 192) - c0, 225);
        check("done count", done_log0.size(), 2);
        check("done latency 1", qget(done_log0, 0) - c0, 223);
        check("done latency 2", qget(done_log0, 1) - c2, 223);
        check("busy cycles", busy_cnt, 222);
        check("rd total", rd_log0.size(), 474);
        check("wr total", wr_log0.size(), 469);
        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int ad = 0; ad < 64; ad++) if (cov[s][ad] != 1) bad++;
            check($sformatf("coverage stage %0d", s), bad, 0);
        end
        check("n4 done latency", qget(done_log1, 0) - e0, 9);
        check("n4 rd2 cycle", qget(rd_log1, 2) - e0, 5);
        check("n4 p0a", qget(pa1, 0), 0); check("n4 p0b", qget(pb1, 0), 1);
        check("n4 p1a", qget(pa1, 1), 2); check("n4 p1b", qget(pb1, 1), 3);
        check("n4 p2a", qget(pa1, 2), 0); check("n4 p2b", qget(pb1, 2), 2);
        check("n4 p3a", qget(pa1, 3), 1); check("n4 p3b", qget(pb1, 3), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
